hazard_stall_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage RISC-V core. It decides when the pipeline must hold or discard instructions, which the operand bypass cannot fix.
- Stalls and holds: load-use stalls in ID, whole-pipeline freezes while data memory is busy.
- Flushes: taken-branch flushes of IF/ID.
- Sits beside the bypass network. Its outputs drive the PC register, the pipeline-register write enables and the bubble-insert controls.
- Keeps saturating stall and flush event counters for performance analysis.

---
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 120 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard/stall controller.
// The controller is the slave: it observes ID/EX/MEM status and drives the
// pipeline-register enables, bubble/flush controls and performance counters.
interface hazard_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       ID_RS1addr_i;
   logic [4:0]       ID_RS2addr_i;
   logic             ID_UsesRS2_i;
   logic             ID_EX_MemRead_i;
   logic [4:0]       ID_EX_RDaddr_i;
   logic             EX_MEM_MemAccess_i;
   logic             mem_ready_i;
   logic             Branch_taken_i;
   logic             PC_write_o;
   logic             IF_ID_write_o;
   logic             IF_ID_flush_o;
   logic             ID_EX_bubble_o;
   logic             pipe_freeze_o;
   logic             mem_timeout_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport master (
      output ID_RS1addr_i, ID_RS2addr_i, ID_UsesRS2_i, ID_EX_MemRead_i,
             ID_EX_RDaddr_i, EX_MEM_MemAccess_i, mem_ready_i, Branch_taken_i,
      input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
             pipe_freeze_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
   );

   modport slave (
      input  ID_RS1addr_i, ID_RS2addr_i, ID_UsesRS2_i, ID_EX_MemRead_i,
             ID_EX_RDaddr_i, EX_MEM_MemAccess_i, mem_ready_i, Branch_taken_i,
      output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
             pipe_freeze_o, mem_timeout_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, data-memory freezes and
// taken-branch flushes, plus saturating stall/flush event counters and a
// sticky memory-wait timeout flag.
module hazard_stall_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 64
) (
   input logic                clk_i,
   input logic                rst_i,
   hazard_stall_ctrl_if.slave bus
);
   localparam int WAIT_W = $clog2(MAX_WAIT) + 1;

   typedef enum logic {
      RUN,
      MEMWAIT
   } state_t;

   state_t           state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             load_use;
   logic             memwait;
   logic [WAIT_W-1:0] wait_inc;

   // Hazard detection: load in EX feeding a source register of ID, and an
   // outstanding data-memory access in MEM.
   always_comb begin
      load_use = bus.ID_EX_MemRead_i && (bus.ID_EX_RDaddr_i != 5'd0) &&
                 ((bus.ID_EX_RDaddr_i == bus.ID_RS1addr_i) ||
                  (bus.ID_UsesRS2_i && (bus.ID_EX_RDaddr_i == bus.ID_RS2addr_i)));
      memwait  = bus.EX_MEM_MemAccess_i && !bus.mem_ready_i;
      wait_inc = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + 1'b1;
   end

   // Next-state and control outputs; a freeze outranks a load-use stall,
   // which outranks a branch flush, so a flush never lands on a held cycle.
   always_comb begin
      // NOTE: every output and next-state value gets a default first so no
      // path through the branches below can infer a latch.
      bus.PC_write_o     = 1'b1;
      bus.IF_ID_write_o  = 1'b1;
      bus.IF_ID_flush_o  = 1'b0;
      bus.ID_EX_bubble_o = 1'b0;
      bus.pipe_freeze_o  = 1'b0;
      state_d            = state_q;
      wait_d             = wait_q;
      timeout_d          = timeout_q;

      if (!rst_i) begin
         bus.PC_write_o    = 1'b0;
         bus.IF_ID_write_o = 1'b0;
         bus.pipe_freeze_o = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (memwait) begin
                  bus.PC_write_o    = 1'b0;
                  bus.IF_ID_write_o = 1'b0;
                  bus.pipe_freeze_o = 1'b1;
                  state_d           = MEMWAIT;
               end else if (load_use) begin
                  bus.PC_write_o     = 1'b0;
                  bus.IF_ID_write_o  = 1'b0;
                  bus.ID_EX_bubble_o = 1'b1;
               end else if (bus.Branch_taken_i) begin
                  bus.IF_ID_flush_o = 1'b1;
               end
            end
            MEMWAIT: begin
               // The ready cycle is still frozen; ID is re-evaluated next cycle.
               bus.PC_write_o    = 1'b0;
               bus.IF_ID_write_o = 1'b0;
               bus.pipe_freeze_o = 1'b1;
               if (bus.mem_ready_i) begin
                  state_d = RUN;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_inc;
                  if (wait_inc >= WAIT_W'(MAX_WAIT)) timeout_d = 1'b1;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Saturating event counters, driven from this cycle's control outputs.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!bus.PC_write_o && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
      if (bus.IF_ID_flush_o && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + 1'b1;
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      if (!rst_i) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign bus.mem_timeout_o = timeout_q;
   assign bus.stall_cnt_o   = stall_q;
   assign bus.flush_cnt_o   = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. A default-width instance and a
// CNT_W=4 instance see identical stimulus; expected control vectors are
// written per step, queued on drive and compared one settle delay later.
module tb_hazard_stall_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;

   hazard_stall_ctrl_if #(.CNT_W(16)) if0 ();
   hazard_stall_ctrl_if #(.CNT_W(4))  if1 ();

   hazard_stall_ctrl #(.CNT_W(16), .MAX_WAIT(64)) dut (
      .clk_i(clk), .rst_i(rst), .bus(if0.slave)
   );
   hazard_stall_ctrl #(.CNT_W(4), .MAX_WAIT(64)) dut_small (
      .clk_i(clk), .rst_i(rst), .bus(if1.slave)
   );

   assign if1.ID_RS1addr_i       = if0.ID_RS1addr_i;
   assign if1.ID_RS2addr_i       = if0.ID_RS2addr_i;
   assign if1.ID_UsesRS2_i       = if0.ID_UsesRS2_i;
   assign if1.ID_EX_MemRead_i    = if0.ID_EX_MemRead_i;
   assign if1.ID_EX_RDaddr_i     = if0.ID_EX_RDaddr_i;
   assign if1.EX_MEM_MemAccess_i = if0.EX_MEM_MemAccess_i;
   assign if1.mem_ready_i        = if0.mem_ready_i;
   assign if1.Branch_taken_i     = if0.Branch_taken_i;

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [4:0] ctl;    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze}
      int         stall;
      int         flush;
      bit         chk_to;
      logic       to;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   m_stall  = 0;
   int   m_flush  = 0;
   bit   chk_to   = 1'b0;
   logic exp_to   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2, input logic mr, input logic [4:0] rd,
                       input logic ma, input logic rdy, input logic br,
                       input logic rst_v, input logic [4:0] ctl);
      exp_t e;
      logic [4:0] got;
      int sm;
      @(negedge clk);
      rst                    = rst_v;
      if0.ID_RS1addr_i       = rs1;
      if0.ID_RS2addr_i       = rs2;
      if0.ID_UsesRS2_i       = u2;
      if0.ID_EX_MemRead_i    = mr;
      if0.ID_EX_RDaddr_i     = rd;
      if0.EX_MEM_MemAccess_i = ma;
      if0.mem_ready_i        = rdy;
      if0.Branch_taken_i     = br;
      exp_q.push_back('{tag, ctl, m_stall, m_flush, chk_to, exp_to});
      #2;
      e   = exp_q.pop_front();
      got = {if0.PC_write_o, if0.IF_ID_write_o, if0.IF_ID_flush_o,
             if0.ID_EX_bubble_o, if0.pipe_freeze_o};
      chk({e.tag, ".ctl"}, 32'(got), 32'(e.ctl));
      chk({e.tag, ".stall_cnt"}, 32'(if0.stall_cnt_o), 32'(e.stall));
      chk({e.tag, ".flush_cnt"}, 32'(if0.flush_cnt_o), 32'(e.flush));
      sm = (e.stall > 15) ? 15 : e.stall;
      chk({e.tag, ".small_stall_cnt"}, 32'(if1.stall_cnt_o), 32'(sm));
      if (e.chk_to) chk({e.tag, ".timeout"}, 32'(if0.mem_timeout_o), 32'(e.to));
      // Advance the counter model with this cycle's expected controls.
      if (!rst_v) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (!ctl[4] && m_stall < 65535) m_stall++;
         if (ctl[2] && m_flush < 65535) m_flush++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: forced freeze, counters and timeout cleared.
      chk_to = 1'b1; exp_to = 1'b0;
      step("reset0", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b00001);
      step("reset1", 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, 5'b00001);
      step("idle0",  5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0, 1, 5'b11000);

      // Load-use on rs1, then back to normal with stall_cnt = 1.
      step("lu_rs1", 5'd5, 5'd2, 0, 1, 5'd5, 0, 1, 0, 1, 5'b00010);
      step("idle1",  5'd1, 5'd2, 0, 0, 5'd5, 0, 1, 0, 1, 5'b11000);

      // rd == x0 never stalls; rs2 only matters when it is used.
      step("rd_x0",     5'd0, 5'd0, 1, 1, 5'd0, 0, 1, 0, 1, 5'b11000);
      step("rs2_unused", 5'd3, 5'd7, 0, 1, 5'd7, 0, 1, 0, 1, 5'b11000);
      step("rs2_used",   5'd3, 5'd7, 1, 1, 5'd7, 0, 1, 0, 1, 5'b00010);

      // Memory wait: 3 busy cycles + ready cycle all frozen, even with a hazard.
      for (int i = 0; i < 3; i++)
         step("memwait", 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 1, 5'b00001);
      step("mem_ready_hz", 5'd5, 5'd2, 0, 1, 5'd5, 1, 1, 0, 1, 5'b00001);
      step("after_mem",    5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 1, 5'b11000);

      // Branch during load-use is deferred; flush on re-presentation.
      step("br_lu",  5'd5, 5'd2, 0, 1, 5'd5, 0, 1, 1, 1, 5'b00010);
      step("br_go",  5'd1, 5'd2, 0, 0, 5'd5, 0, 1, 1, 1, 5'b11100);
      step("idle2",  5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 5'b11000);

      // Branch ignored while frozen, including the ready cycle.
      step("br_mw",    5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 1, 1, 5'b00001);
      step("br_mw_rd", 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 1, 1, 5'b00001);
      step("br_go2",   5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 1, 1, 5'b11100);

      // 20 stall cycles: CNT_W=4 instance saturates at 15.
      for (int i = 0; i < 20; i++)
         step("sat", 5'd9, 5'd2, 0, 1, 5'd9, 0, 1, 0, 1, 5'b00010);
      step("sat_idle", 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 5'b11000);

      // Timeout: 70 busy cycles; flag clear well before 64, set and sticky after.
      for (int i = 1; i <= 70; i++) begin
         chk_to = (i <= 62) || (i >= 67);
         exp_to = (i >= 67);
         step("timeout", 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 1, 5'b00001);
      end
      chk_to = 1'b1; exp_to = 1'b1;
      step("to_rst", 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0, 0, 5'b00001);
      // Back in RUN: access with ready does not freeze; flag cleared.
      exp_to = 1'b0;
      step("to_run", 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, 0, 1, 5'b11000);
      step("to_idle", 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0, 1, 5'b11000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
